mem_block_xfer: RTL

//  Bus master that sits directly upstream of the single-port memory block and drives its valid/ready port.

---
 rtl/mem_block_xfer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_block_xfer.sv
`default_nettype none
// ============================================================================
// Module      : mem_block_xfer
// Description : Block-transfer master for a single-port valid/ready memory.
//               Runs one COPY (read-then-write per word) or FILL (constant
//               write per word) per start pulse. Overlapping copies run
//               descending. A memory that never answers aborts the operation.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_block_xfer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [WIDTH-1:0]      pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    output logic                  mem_wr_rd_o,
    output logic                  mem_valid_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic                  mem_ready_i
);

    // Wait counter holds 0 in the valid cycle and k in the k-th wait cycle.
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     c_wait_last = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]     c_one_wait  = WAIT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_one_addr  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_one_cnt   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_mode, w_mode_nxt;
    logic                  r_desc, w_desc_nxt;
    logic [ADDR_WIDTH:0]   r_len, w_len_nxt;
    logic [WIDTH-1:0]      r_pattern, w_pattern_nxt;
    logic [ADDR_WIDTH-1:0] r_src_ptr, w_src_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_dst_ptr, w_dst_ptr_nxt;
    logic [WAIT_W-1:0]     r_wait, w_wait_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [WIDTH-1:0]      r_wdata, w_wdata_nxt;
    logic                  r_wr_rd, w_wr_rd_nxt;
    logic                  r_valid, w_valid_nxt;

    logic [ADDR_WIDTH:0]   w_src_end;
    logic                  w_desc;
    logic [ADDR_WIDTH-1:0] w_len_lo;
    logic [ADDR_WIDTH-1:0] w_src_first;
    logic [ADDR_WIDTH-1:0] w_dst_first;
    logic [ADDR_WIDTH:0]   w_count_inc;

    // Addresses wrap by truncation, so DEPTH is expected to be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] f_step(input logic [ADDR_WIDTH-1:0] p,
                                                     input logic d);
        return d ? (p - c_one_addr) : (p + c_one_addr);
    endfunction

    // Start-time direction and first addresses; a destination that lands
    // inside the source window must be copied from the top down.
    always_comb begin
        w_src_end   = {1'b0, src_i} + len_i;
        w_desc      = !mode_i && ({1'b0, dst_i} > {1'b0, src_i}) && ({1'b0, dst_i} < w_src_end);
        w_len_lo    = len_i[ADDR_WIDTH-1:0];
        w_src_first = w_desc ? (src_i + w_len_lo - c_one_addr) : src_i;
        w_dst_first = w_desc ? (dst_i + w_len_lo - c_one_addr) : dst_i;
        w_count_inc = r_count + c_one_cnt;
    end

    // Next-state and next-output logic; every output is a register loaded
    // from these values, so an access is presented the cycle after it is issued.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_desc_nxt    = r_desc;
        w_len_nxt     = r_len;
        w_pattern_nxt = r_pattern;
        w_src_ptr_nxt = r_src_ptr;
        w_dst_ptr_nxt = r_dst_ptr;
        w_wait_nxt    = r_wait;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_err_nxt     = r_err;
        w_count_nxt   = r_count;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_wr_rd_nxt   = r_wr_rd;
        w_valid_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_mode_nxt    = mode_i;
                    w_desc_nxt    = w_desc;
                    w_len_nxt     = len_i;
                    w_pattern_nxt = pattern_i;
                    w_count_nxt   = '0;
                    w_err_nxt     = 1'b0;
                    w_wait_nxt    = '0;
                    if (len_i == '0) begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (!mode_i) begin
                        w_addr_nxt    = w_src_first;
                        w_src_ptr_nxt = f_step(w_src_first, w_desc);
                        w_dst_ptr_nxt = w_dst_first;
                        w_wr_rd_nxt   = 1'b0;
                        w_valid_nxt   = 1'b1;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = S_RD_REQ;
                    end else begin
                        w_addr_nxt    = dst_i;
                        w_dst_ptr_nxt = f_step(dst_i, 1'b0);
                        w_wdata_nxt   = pattern_i;
                        w_wr_rd_nxt   = 1'b1;
                        w_valid_nxt   = 1'b1;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = S_WR_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                w_wait_nxt  = r_wait + c_one_wait;
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_ready_i) begin
                    w_addr_nxt    = r_dst_ptr;
                    w_dst_ptr_nxt = f_step(r_dst_ptr, r_desc);
                    w_wdata_nxt   = mem_rdata_i;
                    w_wr_rd_nxt   = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_wait_nxt    = '0;
                    w_state_nxt   = S_WR_REQ;
                end else if (r_wait == c_wait_last) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_wait_nxt = r_wait + c_one_wait;
                end
            end
            S_WR_REQ: begin
                w_wait_nxt  = r_wait + c_one_wait;
                w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (mem_ready_i) begin
                    w_count_nxt = w_count_inc;
                    w_wait_nxt  = '0;
                    if (w_count_inc == r_len) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (!r_mode) begin
                        w_addr_nxt    = r_src_ptr;
                        w_src_ptr_nxt = f_step(r_src_ptr, r_desc);
                        w_wr_rd_nxt   = 1'b0;
                        w_valid_nxt   = 1'b1;
                        w_state_nxt   = S_RD_REQ;
                    end else begin
                        w_addr_nxt    = r_dst_ptr;
                        w_dst_ptr_nxt = f_step(r_dst_ptr, 1'b0);
                        w_wdata_nxt   = r_pattern;
                        w_wr_rd_nxt   = 1'b1;
                        w_valid_nxt   = 1'b1;
                        w_state_nxt   = S_WR_REQ;
                    end
                end else if (r_wait == c_wait_last) begin
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_wait_nxt = r_wait + c_one_wait;
                end
            end
            S_DONE: begin
                // A zero-length request arrives here with done still low and
                // spends one extra cycle raising it.
                w_busy_nxt = 1'b0;
                if (r_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_desc    <= 1'b0;
            r_len     <= '0;
            r_pattern <= '0;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr_rd   <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_desc    <= w_desc_nxt;
            r_len     <= w_len_nxt;
            r_pattern <= w_pattern_nxt;
            r_src_ptr <= w_src_ptr_nxt;
            r_dst_ptr <= w_dst_ptr_nxt;
            r_wait    <= w_wait_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_count   <= w_count_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wr_rd   <= w_wr_rd_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign count_o     = r_count;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_wr_rd_o = r_wr_rd;
    assign mem_valid_o = r_valid;

endmodule
`default_nettype wire
